// File: rtl/nios2_small_oci_dct_pkg.sv
// Shared constants and types for the OCI DCT trace packer.
//   ENTRY_W/ENTRIES/CNT_W : code width, codes per buffer, count width
//   dct_code_e            : DCT code encoding from the trace front end
//   TW_TAG_DCT            : frame tag placed between count and buffer
//   slot_state_e          : output holding-slot state
package nios2_small_oci_dct_pkg;
  localparam int ENTRY_W = 2;
  localparam int ENTRIES = 15;
  localparam int CNT_W   = 4;
  localparam int BUF_W   = ENTRY_W * ENTRIES;
  localparam int TW_W    = CNT_W + 2 + BUF_W;

  typedef enum logic [1:0] {
    DCT_FILL = 2'b00,
    DCT_NT   = 2'b01,
    DCT_TK   = 2'b10,
    DCT_EXC  = 2'b11
  } dct_code_e;

  localparam logic [1:0] TW_TAG_DCT = 2'b10;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;
endpackage

// File: rtl/nios2_small_oci_tw_slot.sv
// Single-entry valid/ready holding register for sealed trace words.
//   load/data_in : capture a new word (caller only loads when the slot is
//                  empty or being drained this cycle)
//   ready        : downstream accepts the held word
//   valid/data   : held word, registered
module nios2_small_oci_tw_slot #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] data_in,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);
  import nios2_small_oci_dct_pkg::*;

  slot_state_e state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SLOT_EMPTY;
      valid <= 1'b0;
      data  <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (load) begin
            state <= SLOT_FULL;
            valid <= 1'b1;
            data  <= data_in;
          end
        end
        SLOT_FULL: begin
          // load here implies ready: the old word leaves as the new one lands
          if (load) begin
            data <= data_in;
          end else if (ready) begin
            state <= SLOT_EMPTY;
            valid <= 1'b0;
          end
        end
        default: begin
          state <= SLOT_EMPTY;
          valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/nios2_small_nios2_qsys_oci_dct_packer.sv
// OCI DCT trace packer: shifts one 2-bit DCT code per cycle into a live
// buffer, seals it into a trace word when full or on flush, and hands the
// word to trace memory through a single-entry valid/ready slot.
//   dct_valid/dct_code    : incoming code
//   flush                 : request to seal a partial buffer
//   ovf_clear             : clear sticky overflow
//   dct_buffer/dct_count  : live buffer (newest code in [1:0]) and count
//   tw_valid/tw_ready/tw_data : trace word {count, tag, buffer}
//   overflow              : sticky, set when a code is dropped
module nios2_small_nios2_qsys_oci_dct_packer #(
  parameter int ENTRY_W = 2,
  parameter int ENTRIES = 15,
  parameter int CNT_W   = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             dct_valid,
  input  logic [ENTRY_W-1:0]               dct_code,
  input  logic                             flush,
  input  logic                             ovf_clear,
  output logic [ENTRY_W*ENTRIES-1:0]       dct_buffer,
  output logic [CNT_W-1:0]                 dct_count,
  output logic                             tw_valid,
  input  logic                             tw_ready,
  output logic [CNT_W+2+ENTRY_W*ENTRIES-1:0] tw_data,
  output logic                             overflow
);
  import nios2_small_oci_dct_pkg::TW_TAG_DCT;

  localparam int BUF_W = ENTRY_W * ENTRIES;
  localparam int TW_W  = CNT_W + 2 + BUF_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ENTRIES);

  logic             flush_pend;
  logic             full, slot_free, seal, drop, pend_n;
  logic [CNT_W-1:0] count_n;
  logic [BUF_W-1:0] buffer_n;
  logic [TW_W-1:0]  word;

  always_comb begin
    full      = (dct_count == CNT_FULL);
    slot_free = !tw_valid || tw_ready;
    seal      = slot_free && (full || (flush_pend && dct_count != '0));
    drop      = dct_valid && full && !seal;
    word      = {dct_count, TW_TAG_DCT, dct_buffer};

    buffer_n = dct_buffer;
    count_n  = dct_count;
    if (seal) begin
      buffer_n = '0;
      count_n  = '0;
    end
    // after a seal the code lands in the freshly cleared buffer
    if (dct_valid && !drop) begin
      buffer_n = {buffer_n[BUF_W-ENTRY_W-1:0], dct_code};
      count_n  = count_n + CNT_W'(1);
    end
    // a flush that leaves nothing buffered has nothing to seal
    pend_n = (flush || (flush_pend && !seal)) && (count_n != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dct_buffer <= buffer_n;
      dct_count  <= count_n;
      flush_pend <= pend_n;
      if (ovf_clear)  overflow <= 1'b0;
      else if (drop)  overflow <= 1'b1;
    end
  end

  nios2_small_oci_tw_slot #(.W(TW_W)) u_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (seal),
    .data_in (word),
    .ready   (tw_ready),
    .valid   (tw_valid),
    .data    (tw_data)
  );
endmodule

// File: doc/nios2_small_nios2_qsys_oci_dct_packer.md
# nios2_small_nios2_qsys_oci_dct_packer

Producer side of the OCI direct-control-transfer (DCT) trace path in the `nios2_small` SOPC. It accepts one 2-bit DCT code per cycle from the CPU trace front end and packs the codes into a 30-bit buffer with a 4-bit entry count. That live buffer/count pair is what the OCI test-bench monitor samples. Each sealed buffer (full, or on flush) is emitted as a 36-bit trace word to trace memory over a valid/ready handshake.

## Interface
Parameters:
- `ENTRY_W`, 2: bits per DCT code.
- `ENTRIES`, 15: codes per buffer; buffer width = `ENTRY_W*ENTRIES` = 30.
- `CNT_W`, 4: count width; must hold `ENTRIES`.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `dct_valid`  in  1  `dct_code` is presented this cycle.
- `dct_code`  in  2  `01` not-taken, `10` taken, `11` exception, `00` filler; all four are packed.
- `flush`  in  1  single-cycle request to seal a partial buffer.
- `ovf_clear`  in  1  clears `overflow`.
- `dct_buffer`  out  30  live packing buffer, newest code in `[1:0]`.
- `dct_count`  out  4  number of valid codes in `dct_buffer`, 0..15.
- `tw_valid`  out  1  trace word is held in the output slot.
- `tw_ready`  in  1  trace memory accepts the word this cycle.
- `tw_data`  out  36  `{count[3:0], 2'b10 tag, buffer[29:0]}`.
- `overflow`  out  1  sticky; set when a code is dropped.

## Operation
- Accept, when the buffer is not full or a seal happens this cycle:
  - `dct_buffer <= {dct_buffer[27:0], dct_code}`
  - `dct_count <= dct_count + 1`
- Output slot FSM has two states:
  - EMPTY -> FULL on seal.
  - FULL -> EMPTY on `tw_ready` with no seal.
  - FULL -> FULL on `tw_ready` with a seal (back-to-back, no bubble).
- `slot_free = !tw_valid || tw_ready`.
- Seal condition is `slot_free` and (`dct_count == 15`, or `flush_pend` with `dct_count != 0`). On seal:
  - `tw_data` is loaded with the current count, tag and buffer.
  - The live buffer clears.
  - If `dct_valid` is high the same cycle, the new code enters the cleared buffer: `dct_buffer = {28'b0, code}`, `dct_count = 1`.
- Full with no seal (slot busy) and `dct_valid` high: the code is dropped and `overflow` is set. Buffer contents are unchanged.
- `flush_pend`:
  - Set by `flush`.
  - Cleared on seal, or immediately when `dct_count == 0` and no code arrives that cycle (an empty flush produces no frame).
  - `flush` together with `dct_valid` packs the code first; the seal follows on the next eligible cycle.
- `ovf_clear` has priority over a same-cycle set.
- Reset (async assert, sync-safe deassert) forces `dct_buffer=0`, `dct_count=0`, `tw_valid=0`, `tw_data=0`, `overflow=0`, `flush_pend=0`, FSM=EMPTY. This applies mid-frame as well; in-flight data is discarded.

## Timing
- All outputs are registered; no combinational path from input to output.
- Code accepted at edge k is visible on `dct_buffer`/`dct_count` after edge k.
- Seal is evaluated on registered state: `dct_count == 15` after edge k gives `tw_valid = 1` after edge k+1 if the slot is free.
- `flush` sampled at edge k with a free slot and nonzero count gives `tw_valid` after edge k+1.
- `tw_data` holds stable while `tw_valid && !tw_ready`.
- Sustained throughput is one code per cycle with `tw_ready` held high; no codes are lost.

## Structure
- Package `nios2_small_oci_dct_pkg` holds:
  - `ENTRY_W`, `ENTRIES`, `CNT_W`
  - the DCT code enum (`DCT_FILL`, `DCT_NT`, `DCT_TK`, `DCT_EXC`)
  - the frame tag constant `TW_TAG_DCT = 2'b10`
  - the slot state enum
- One sub-module, `nios2_small_oci_tw_slot`: the single-entry valid/ready holding register with `load`/`data_in`. The packer keeps the buffer, count, flush and overflow logic.

## Test plan
- 15 × `dct_code=10` back-to-back, `tw_ready=1`:
  - `tw_valid` one cycle after `dct_count==15`.
  - `tw_data = {4'hF, 2'b10, 30'h2AAAAAAA}`.
  - Count returns to 0.
- Codes 01, 10, 11 then `flush`: `tw_data = {4'h3, 2'b10, 30'h0000001B}`, `dct_count=0`.
- `flush` with `dct_count=0`: `tw_valid` stays 0 and `flush_pend` clears.
- `tw_ready=0`, 31 codes:
  - Frame 1 is held in the slot.
  - Codes 16–30 fill the buffer to 15; code 31 is dropped and `overflow=1`.
  - Raising `tw_ready` delivers frame 1 and then frame 2 in order.
  - `ovf_clear` drops `overflow`.
- Slot FULL, `tw_ready=1`, `dct_count=15`, `dct_valid=1` all in one cycle:
  - New frame is loaded with no bubble.
  - `dct_buffer=0x0000000x` holding the new code, `dct_count=1`.
- `reset_n` low mid-frame (`dct_count=7`, `tw_valid=1`): all outputs go to 0 asynchronously, and the first frame after reset starts from count 0.
